fixpoint_mac_accum: RTL
=======================

Name: fixpoint_mac_accum

Overview:
- Downstream consumer of the signed fixed-point multiplier stage.
- Takes full-precision signed products (Q(2W-2P).(2P)), rescales each to Q(W-P).P with round-half-up, and accumulates a window of cfg_len terms with guard bits.
- Emits one saturated WIDTH-bit result per window over a valid/ready handshake.
- Forms the dot-product/convolution-sum stage of the CNN datapath.

Parameters:
- WIDTH, 32, operand/result width (signed).
- POINT_WIDTH, 16, fractional bits of operand/result; product has 2*POINT_WIDTH.
- LEN_WIDTH, 8, width of window-length input.
- ACC_GUARD, 8, extra accumulator MSBs above the rescaled term width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  product beat valid.
- in_ready  out  1  block can accept a beat.
- in_prod  in  2*WIDTH  signed product.
- cfg_len  in  LEN_WIDTH  terms per window; sampled on first beat of a window.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_data  out  WIDTH  saturated signed result.
- out_sat  out  1  result was clipped.
- busy  out  1  window in progress (state ACCUM).

Behaviour:
- Interface: reset rst_n, asynchronous, active-low; clock clk. All state updates on posedge clk.
- Reset values: in_ready=1, out_valid=0, out_data=0, out_sat=0, busy=0; accumulator=0, count=0, state=IDLE.
- Term width TW = 2*WIDTH-POINT_WIDTH (48). Accumulator width AW = TW+ACC_GUARD (56).
- Rescale: term = (in_prod + 2^(POINT_WIDTH-1)) >>> POINT_WIDTH, arithmetic shift, computed at 2*WIDTH bits, truncated to TW bits (lossless). Round-half-up, including for negatives (-0.5 LSB -> 0).
- Handshake: beat accepted when in_valid && in_ready. in_ready = !out_valid. Output transfer when out_valid && out_ready. No combinational path from out_ready to in_ready.
- FSM:
  - IDLE: on accepted beat, latch len = (cfg_len==0 ? 1 : cfg_len), acc = term, count = 1. If len==1, go to OUT; else go to ACCUM.
  - ACCUM: on each accepted beat, acc += term, count++. When count reaches len, go to OUT. Cycles without a beat hold state.
  - OUT: out_valid=1 in the cycle after the last term is accepted (latency 1). out_data/out_sat are registered from the final acc and held stable until out_ready. On transfer, go to IDLE with out_valid=0. A beat arriving in that same cycle is not accepted because in_ready=0.
- Saturation: if final acc > 2^(WIDTH-1)-1, out_data=0x7FFFFFFF and out_sat=1. If acc < -2^(WIDTH-1), out_data=0x80000000 and out_sat=1. Otherwise out_data=acc[WIDTH-1:0] and out_sat=0.
- Accumulator wrap: no internal wrap for windows up to 2^ACC_GUARD terms of any magnitude. Longer windows are outside the supported range (no detection).
- cfg_len changes mid-window are ignored.
- Throughput: one window of N terms per N+1 cycles minimum.
- Reset mid-window or mid-OUT: all state is cleared immediately and the partial sum is discarded.

Optional Feature:
- Macro FIXMAC_RELU_EN.
- Defined: after saturation, a negative result is forced to out_data=0. out_sat still reports clipping from the saturation step only. Adds no latency.
- Undefined: signed result passed as-is.

Test Plan:
- Basic: cfg_len=1, in_prod=0x0000000300000000 (1.5*2.0) -> one cycle later out_valid=1, out_data=0x00030000, out_sat=0.
- Rounding: cfg_len=2, products 0x0000000000008000 and 0xFFFFFFFFFFFF8000 -> terms 1 and 0, out_data=0x00000001.
- Saturation: cfg_len=4, four beats of 0x0000400000000000 (term 0x40000000) -> out_data=0x7FFFFFFF, out_sat=1. Negated products -> 0x80000000, out_sat=1. With FIXMAC_RELU_EN -> 0x00000000, out_sat=1.
- Back-pressure: cfg_len=3, hold out_ready=0 for 5 cycles after out_valid -> out_data stable, in_ready=0 throughout, next window's first beat accepted only after transfer.
- Gaps/len edge: cfg_len=0 with one beat 0x0000000100000000 -> out_data=0x00010000. cfg_len=3 with in_valid deasserted between beats -> busy=1 until the 3rd beat, correct sum.
- Reset mid-window: assert rst_n=0 after 2 of 4 beats -> out_valid=0, in_ready=1. A new window cfg_len=1 of 0x0000000200000000 -> out_data=0x00020000 (no stale sum).

Source files
------------

// File: rtl/fixpoint_mac_accum.sv
// fixpoint_mac_accum: rescales Q(2W-2P).(2P) products to Q(W-P).P with round-half-up and accumulates a window of terms
// into one saturated result per window; define FIXMAC_RELU_EN to clamp negative results to zero.
module fixpoint_mac_accum #(
   parameter int WIDTH       = 32,
   parameter int POINT_WIDTH = 16,
   parameter int LEN_WIDTH   = 8,
   parameter int ACC_GUARD   = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [2*WIDTH-1:0]     in_prod,
   input  logic [LEN_WIDTH-1:0]   cfg_len,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [WIDTH-1:0]       out_data,
   output logic                   out_sat,
   output logic                   busy
);
   localparam int TW = 2*WIDTH-POINT_WIDTH;
   localparam int AW = TW+ACC_GUARD;
   localparam logic [1:0] IDLE = 2'd0, ACCUM = 2'd1, OUT = 2'd2;
   localparam logic signed [2*WIDTH-1:0] HALF = (2*WIDTH)'(1) << (POINT_WIDTH-1);
   localparam logic signed [AW-1:0] MAXV = {{(AW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
   localparam logic signed [AW-1:0] MINV = {{(AW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
   logic [1:0] state;
   logic signed [AW-1:0] acc, sum;
   logic signed [TW-1:0] term;
   logic [LEN_WIDTH-1:0] count, len, eff_len;
   logic accept, last, hi, lo;
   logic [WIDTH-1:0] sat_data, res;
   // Rounded shift done at full product width; the top TW bits hold the whole result.
   assign term = TW'(($signed(in_prod) + HALF) >>> POINT_WIDTH);
   assign in_ready = !out_valid;
   assign busy = state == ACCUM;
   always_comb begin
      accept = in_valid && in_ready;
      eff_len = cfg_len == '0 ? LEN_WIDTH'(1) : cfg_len;
      sum = (state == ACCUM ? acc : '0) + {{ACC_GUARD{term[TW-1]}}, term};
      last = state == IDLE ? eff_len == LEN_WIDTH'(1) : count + LEN_WIDTH'(1) == len;
      hi = sum > MAXV;
      lo = sum < MINV;
      sat_data = hi ? {1'b0, {(WIDTH-1){1'b1}}} : lo ? {1'b1, {(WIDTH-1){1'b0}}} : sum[WIDTH-1:0];
   end
`ifdef FIXMAC_RELU_EN
   assign res = sat_data[WIDTH-1] ? '0 : sat_data;
`else
   assign res = sat_data;
`endif
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         acc       <= '0;
         count     <= '0;
         len       <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sat   <= 1'b0;
      end else begin
         if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
         end
         if (accept) begin
            acc   <= sum;
            count <= state == IDLE ? LEN_WIDTH'(1) : count + LEN_WIDTH'(1);
            if (state == IDLE) len <= eff_len;
            if (last) begin
               state     <= OUT;
               out_valid <= 1'b1;
               out_data  <= res;
               out_sat   <= hi || lo;
            end else begin
               state <= ACCUM;
            end
         end
      end
   end
endmodule
